fir_cdc_reg_bank: RTL and testbench

Domain-B register responder that terminates the CDC write/read channel (CDC_A, CDC_data, CDC_wr, data_back) driven by cdc_module.
- Decodes the 6-bit address space into control, status, length, ID and a 32-entry coefficient bank for the FIR core.
- Sequences FIR runs with a start/done handshake.
- Double-buffers coefficients so host writes never disturb a running filter.

---
 rtl/fir_cdc_reg_bank.sv | 150 +++++++++++++++
 tb/tb_fir_cdc_reg_bank.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_cdc_reg_bank.sv
// Domain-B register responder for the CDC write/read channel. Decodes control,
// status, sample length, ID and a double-buffered 32-entry coefficient bank,
// and sequences FIR runs with a start/done handshake.
module fir_cdc_reg_bank #(
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       ADDR_W   = 6,
  parameter int unsigned       N_TAPS   = 32,
  parameter logic [DATA_W-1:0] ID_VALUE = 16'hF1C0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] CDC_A,
  input  logic [DATA_W-1:0] CDC_data,
  input  logic              CDC_wr,
  output logic [DATA_W-1:0] data_back,
  input  logic [4:0]        coef_addr,
  output logic [DATA_W-1:0] coef_data,
  output logic              fir_start,
  input  logic              fir_done,
  output logic              fir_enable,
  output logic [DATA_W-1:0] sample_len
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  logic [0:0]        state_q;
  logic              wr_q;
  logic              enable_q;
  logic              done_q;
  logic              wr_err_q;
  logic              start_rej_q;
  logic [DATA_W-1:0] len_q;
  logic [DATA_W-1:0] shadow_q [N_TAPS];
  logic [DATA_W-1:0] active_q [N_TAPS];

  logic              wr_rise;
  logic              is_coef;
  logic              wr_ctrl;
  logic              wr_len;
  logic              wr_bad;
  logic              start_ok;
  logic              start_rej_set;
  logic              stop_run;
  logic              done_set;
  logic              clr_flags;
  logic [DATA_W-1:0] rd_data;

  // A held CDC_wr level yields a single write on its rising edge.
  assign wr_rise = CDC_wr & ~wr_q;
  assign is_coef = CDC_A[5];
  assign wr_ctrl = wr_rise && (CDC_A == 6'd0);
  assign wr_len  = wr_rise && (CDC_A == 6'd2);
  // Writes to STATUS, ID and the reserved hole only flag an error.
  assign wr_bad  = wr_rise && !is_coef && (CDC_A != 6'd0) && (CDC_A != 6'd2);

  // START needs the written ENABLE bit set and an idle sequencer.
  assign start_ok      = wr_ctrl && CDC_data[1] && CDC_data[0] && (state_q == StIdle);
  assign start_rej_set = wr_ctrl && CDC_data[1] && !start_ok;
  // Dropping ENABLE aborts a run; a coincident fir_done is ignored.
  assign stop_run      = wr_ctrl && !CDC_data[0] && (state_q == StRun);
  assign done_set      = (state_q == StRun) && fir_done && !stop_run;
  assign clr_flags     = wr_ctrl && CDC_data[2];

  assign fir_enable = enable_q;
  assign sample_len = len_q;

  // Read multiplexer on pre-edge register values.
  always_comb begin
    rd_data = '0;
    if (is_coef) begin
      rd_data = shadow_q[CDC_A[4:0]];
    end else begin
      case (CDC_A[4:0])
        5'd0:    rd_data[0]   = enable_q;
        5'd1:    rd_data[3:0] = {start_rej_q, wr_err_q, done_q, state_q == StRun};
        5'd2:    rd_data      = len_q;
        5'd3:    rd_data      = ID_VALUE;
        default: rd_data      = '0;
      endcase
    end
  end

  // Control, status flags and run sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      wr_q        <= 1'b0;
      enable_q    <= 1'b0;
      done_q      <= 1'b0;
      wr_err_q    <= 1'b0;
      start_rej_q <= 1'b0;
      len_q       <= '0;
      fir_start   <= 1'b0;
    end else begin
      wr_q      <= CDC_wr;
      fir_start <= start_ok;
      if (wr_ctrl) enable_q <= CDC_data[0];
      if (wr_len)  len_q    <= CDC_data;

      if (start_ok) begin
        state_q <= StRun;
      end else if (stop_run || done_set) begin
        state_q <= StIdle;
      end

      // Set events take priority over CLR_DONE in the same cycle.
      if (done_set) begin
        done_q <= 1'b1;
      end else if (clr_flags || start_ok) begin
        done_q <= 1'b0;
      end
      if (wr_bad) begin
        wr_err_q <= 1'b1;
      end else if (clr_flags) begin
        wr_err_q <= 1'b0;
      end
      if (start_rej_set) begin
        start_rej_q <= 1'b1;
      end else if (clr_flags) begin
        start_rej_q <= 1'b0;
      end
    end
  end

  // Host writes land in the shadow bank; an accepted START snapshots it into the active bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_TAPS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      if (wr_rise && is_coef) shadow_q[CDC_A[4:0]] <= CDC_data;
      if (start_ok) active_q <= shadow_q;
    end
  end

  // Registered read-back and coefficient outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_back <= '0;
      coef_data <= '0;
    end else begin
      data_back <= wr_rise ? CDC_data : rd_data;
      coef_data <= active_q[coef_addr];
    end
  end

endmodule

// File: tb/tb_fir_cdc_reg_bank.sv
// Self-checking bench for fir_cdc_reg_bank against a transaction-level model.
module tb_fir_cdc_reg_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  CDC_A = '0;
  logic [15:0] CDC_data = '0;
  logic        CDC_wr = 1'b0;
  logic [15:0] data_back;
  logic [4:0]  coef_addr = '0;
  logic [15:0] coef_data;
  logic        fir_start;
  logic        fir_done = 1'b0;
  logic        fir_enable;
  logic [15:0] sample_len;

  int n_pass = 0;
  int n_total = 0;

  // Reference model state.
  bit          m_en, m_busy, m_done, m_err, m_rej;
  logic [15:0] m_len;
  logic [15:0] m_shadow [32];
  logic [15:0] m_active [32];

  fir_cdc_reg_bank dut (
    .clk        (clk),
    .rst        (rst),
    .CDC_A      (CDC_A),
    .CDC_data   (CDC_data),
    .CDC_wr     (CDC_wr),
    .data_back  (data_back),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .fir_start  (fir_start),
    .fir_done   (fir_done),
    .fir_enable (fir_enable),
    .sample_len (sample_len)
  );

  always #5 clk = ~clk;

  task automatic mdl_reset();
    m_en = 0; m_busy = 0; m_done = 0; m_err = 0; m_rej = 0; m_len = '0;
    for (int i = 0; i < 32; i++) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
    end
  endtask

  function automatic logic [15:0] mdl_read(input logic [5:0] a);
    if (a >= 6'd32) return m_shadow[a - 6'd32];
    case (a)
      6'd0:    return {15'd0, m_en};
      6'd1:    return {12'd0, m_rej, m_err, m_done, m_busy};
      6'd2:    return m_len;
      6'd3:    return 16'hF1C0;
      default: return 16'h0000;
    endcase
  endfunction

  // One accepted host write, with an optional coincident fir_done.
  task automatic mdl_write(input logic [5:0] a, input logic [15:0] d, input bit fd,
                           output bit acc);
    bit rej, stop, dset;
    acc = 0; rej = 0; stop = 0;
    if (a == 6'd0) begin
      acc  = d[1] && d[0] && !m_busy;
      rej  = d[1] && !acc;
      stop = m_busy && !d[0];
    end
    dset = m_busy && fd && !stop;
    if (a == 6'd0 && d[2]) begin
      m_done = 0; m_err = 0; m_rej = 0;
    end
    if (acc) begin
      m_done = 0;
      m_active = m_shadow;
    end
    if (dset) m_done = 1;
    if (rej) m_rej = 1;
    if (a != 6'd0 && a != 6'd2 && a < 6'd32) m_err = 1;
    if (a == 6'd2) m_len = d;
    if (a >= 6'd32) m_shadow[a - 6'd32] = d;
    if (a == 6'd0) m_en = d[0];
    if (acc) m_busy = 1;
    else if (stop || dset) m_busy = 0;
  endtask

  // Drive a write held for 'hold' cycles; capture data_back on the write edge,
  // fir_start on that edge and the next, and data_back once CDC_wr has dropped.
  task automatic do_write(input logic [5:0] a, input logic [15:0] d, input int hold,
                          input bit fd, input logic [15:0] d_hold,
                          output logic [15:0] db_w, output logic st1, output logic st2,
                          output logic [15:0] db_after, output bit acc);
    @(negedge clk);
    CDC_A = a; CDC_data = d; CDC_wr = 1'b1; fir_done = fd;
    @(posedge clk); #1;
    db_w = data_back; st1 = fir_start;
    mdl_write(a, d, fd, acc);
    st2 = 1'b0;
    for (int k = 1; k < hold; k++) begin
      @(negedge clk);
      fir_done = 1'b0; CDC_data = d_hold;
      @(posedge clk); #1;
      if (k == 1) st2 = fir_start;
    end
    @(negedge clk);
    CDC_wr = 1'b0; fir_done = 1'b0;
    @(posedge clk); #1;
    if (hold <= 1) st2 = fir_start;
    db_after = data_back;
  endtask

  task automatic do_read(input logic [5:0] a, output logic [15:0] v);
    @(negedge clk);
    CDC_A = a; CDC_wr = 1'b0;
    @(posedge clk); #1;
    v = data_back;
  endtask

  task automatic coef_read(input logic [4:0] idx, output logic [15:0] v);
    @(negedge clk);
    coef_addr = idx;
    @(posedge clk); #1;
    v = coef_data;
  endtask

  task automatic pulse_done();
    @(negedge clk);
    fir_done = 1'b1;
    @(posedge clk); #1;
    if (m_busy) begin
      m_busy = 0;
      m_done = 1;
    end
    @(negedge clk);
    fir_done = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] v;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mdl_reset();
    n_total++;
    if ({data_back, coef_data, sample_len, fir_start, fir_enable} !== 50'd0)
      $display("FAIL reset_outputs: got db=%h cd=%h len=%h st=%b en=%b, want all 0",
               data_back, coef_data, sample_len, fir_start, fir_enable);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    do_read(6'd3, v);
    n_total++;
    if (v !== 16'hF1C0) $display("FAIL read_id: got %h want f1c0", v); else n_pass++;
    for (int a = 0; a < 3; a++) begin
      do_read(6'(a), v);
      n_total++;
      if (v !== 16'h0000) $display("FAIL reset_read_%0d: got %h want 0000", a, v);
      else n_pass++;
    end
  endtask

  task automatic test_single_write();
    logic [15:0] dbw, dba, v;
    logic s1, s2;
    bit acc;
    do_write(6'h20, 16'h1111, 5, 1'b0, 16'hFFFF, dbw, s1, s2, dba, acc);
    n_total++;
    if (dbw !== 16'h1111) $display("FAIL write_through: got %h want 1111", dbw); else n_pass++;
    n_total++;
    if (dba !== 16'h1111) $display("FAIL held_one_write: got %h want 1111", dba); else n_pass++;
    do_read(6'h20, v);
    n_total++;
    if (v !== m_shadow[0]) $display("FAIL read_coef0: got %h want %h", v, m_shadow[0]);
    else n_pass++;
  endtask

  task automatic test_run();
    logic [15:0] dbw, dba, v;
    logic s1, s2;
    bit acc;
    do_write(6'h00, 16'h0003, 1, 1'b0, 16'h0003, dbw, s1, s2, dba, acc);
    n_total++;
    if ({s1, s2} !== 2'b10) $display("FAIL start_pulse: got %b%b want 10", s1, s2);
    else n_pass++;
    do_read(6'h01, v);
    n_total++;
    if (v !== 16'h0001) $display("FAIL status_busy: got %h want 0001", v); else n_pass++;
    coef_read(5'd0, v);
    n_total++;
    if (v !== 16'h1111) $display("FAIL active_coef0: got %h want 1111", v); else n_pass++;
    pulse_done();
    do_read(6'h01, v);
    n_total++;
    if (v !== 16'h0002) $display("FAIL status_done: got %h want 0002", v); else n_pass++;
  endtask

  task automatic test_run_isolation();
    logic [15:0] dbw, dba, v;
    logic s1, s2;
    bit acc;
    do_write(6'h00, 16'h0003, 1, 1'b0, 16'h0003, dbw, s1, s2, dba, acc);
    do_write(6'h20, 16'hBEEF, 1, 1'b0, 16'hBEEF, dbw, s1, s2, dba, acc);
    coef_read(5'd0, v);
    n_total++;
    if (v !== 16'h1111) $display("FAIL active_held: got %h want 1111", v); else n_pass++;
    do_read(6'h20, v);
    n_total++;
    if (v !== 16'hBEEF) $display("FAIL shadow_updated: got %h want beef", v); else n_pass++;
    do_write(6'h00, 16'h0003, 1, 1'b0, 16'h0003, dbw, s1, s2, dba, acc);
    n_total++;
    if ({s1, s2} !== 2'b00) $display("FAIL start_in_run: got %b%b want 00", s1, s2);
    else n_pass++;
    do_read(6'h01, v);
    n_total++;
    if (v !== 16'h0009) $display("FAIL status_rej: got %h want 0009", v); else n_pass++;
    pulse_done();
    do_write(6'h00, 16'h0003, 1, 1'b0, 16'h0003, dbw, s1, s2, dba, acc);
    coef_read(5'd0, v);
    n_total++;
    if (v !== 16'hBEEF) $display("FAIL active_copied: got %h want beef", v); else n_pass++;
    pulse_done();
  endtask

  task automatic test_errors();
    logic [15:0] dbw, dba, v;
    logic s1, s2;
    bit acc;
    do_write(6'h01, 16'h1234, 1, 1'b0, 16'h1234, dbw, s1, s2, dba, acc);
    do_write(6'h10, 16'h5678, 1, 1'b0, 16'h5678, dbw, s1, s2, dba, acc);
    do_read(6'h01, v);
    n_total++;
    if (v[2] !== 1'b1 || v !== mdl_read(6'h01))
      $display("FAIL wr_err_set: got %h want %h", v, mdl_read(6'h01));
    else n_pass++;
    do_read(6'h10, v);
    n_total++;
    if (v !== 16'h0000) $display("FAIL reserved_read: got %h want 0000", v); else n_pass++;
    do_write(6'h00, 16'h0005, 1, 1'b1, 16'h0005, dbw, s1, s2, dba, acc);
    do_read(6'h01, v);
    n_total++;
    if (v !== 16'h0000) $display("FAIL clr_flags: got %h want 0000", v); else n_pass++;
    do_write(6'h00, 16'h0003, 1, 1'b0, 16'h0003, dbw, s1, s2, dba, acc);
    do_write(6'h00, 16'h0000, 1, 1'b0, 16'h0000, dbw, s1, s2, dba, acc);
    do_read(6'h01, v);
    n_total++;
    if (v !== 16'h0000) $display("FAIL abort_run: got %h want 0000", v); else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] dbw, dba, v;
    logic s1, s2;
    bit acc;
    do_write(6'h02, 16'h00FF, 1, 1'b0, 16'h00FF, dbw, s1, s2, dba, acc);
    do_write(6'h00, 16'h0003, 1, 1'b0, 16'h0003, dbw, s1, s2, dba, acc);
    @(negedge clk);
    rst = 1'b1; CDC_A = 6'h21; CDC_data = 16'hA5A5; CDC_wr = 1'b1;
    @(posedge clk); #1;
    mdl_reset();
    n_total++;
    if ({data_back, coef_data, sample_len, fir_start, fir_enable} !== 50'd0)
      $display("FAIL reset_mid_run: got db=%h cd=%h len=%h st=%b en=%b, want all 0",
               data_back, coef_data, sample_len, fir_start, fir_enable);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    mdl_write(6'h21, 16'hA5A5, 1'b0, acc);
    n_total++;
    if (data_back !== 16'hA5A5) $display("FAIL wr_across_reset: got %h want a5a5", data_back);
    else n_pass++;
    @(negedge clk);
    CDC_data = 16'h5A5A;
    @(posedge clk);
    @(negedge clk);
    CDC_wr = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if (data_back !== mdl_read(6'h21))
      $display("FAIL single_write_after_reset: got %h want %h", data_back, mdl_read(6'h21));
    else n_pass++;
    do_read(6'h01, v);
    n_total++;
    if (v !== 16'h0000) $display("FAIL status_after_reset: got %h want 0000", v); else n_pass++;
    do_read(6'h02, v);
    n_total++;
    if (v !== 16'h0000) $display("FAIL len_after_reset: got %h want 0000", v); else n_pass++;
  endtask

  task automatic test_random();
    logic [15:0] dbw, dba, v, d;
    logic [5:0]  a;
    logic [4:0]  idx;
    logic s1, s2;
    bit acc, fd;
    int op, hold;
    for (int it = 0; it < 80; it++) begin
      op = $urandom_range(0, 5);
      case (op)
        0, 1, 5: begin
          if (op == 0) a = 6'(32 + $urandom_range(0, 31));
          else if (op == 1) a = 6'd0;
          else a = 6'($urandom_range(0, 63));
          d = 16'($urandom);
          if (op == 1) d = {d[15:3], 3'($urandom_range(0, 7))};
          hold = $urandom_range(1, 3);
          fd = ($urandom_range(0, 3) == 0);
          do_write(a, d, hold, fd, 16'($urandom), dbw, s1, s2, dba, acc);
          n_total++;
          if (dbw !== d) $display("FAIL rnd_wthru a=%h: got %h want %h", a, dbw, d);
          else n_pass++;
          n_total++;
          if ({s1, s2} !== {acc, 1'b0})
            $display("FAIL rnd_start a=%h d=%h: got %b%b want %b0", a, d, s1, s2, acc);
          else n_pass++;
          n_total++;
          if (dba !== mdl_read(a))
            $display("FAIL rnd_wread a=%h: got %h want %h", a, dba, mdl_read(a));
          else n_pass++;
        end
        2: begin
          a = 6'($urandom_range(0, 63));
          do_read(a, v);
          n_total++;
          if (v !== mdl_read(a)) $display("FAIL rnd_read a=%h: got %h want %h", a, v, mdl_read(a));
          else n_pass++;
        end
        3: begin
          pulse_done();
          do_read(6'h01, v);
          n_total++;
          if (v !== mdl_read(6'h01))
            $display("FAIL rnd_done_status: got %h want %h", v, mdl_read(6'h01));
          else n_pass++;
        end
        default: begin
          idx = 5'($urandom_range(0, 31));
          coef_read(idx, v);
          n_total++;
          if (v !== m_active[idx])
            $display("FAIL rnd_coef idx=%0d: got %h want %h", idx, v, m_active[idx]);
          else n_pass++;
        end
      endcase
      n_total++;
      if ({fir_enable, sample_len} !== {m_en, m_len})
        $display("FAIL rnd_outs: got en=%b len=%h want en=%b len=%h",
                 fir_enable, sample_len, m_en, m_len);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_run();
    test_run_isolation();
    test_errors();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
